// File: rtl/f15_unpack.sv
// f15_unpack: receive-side unpacker for the fosphor frame stream.
// Tracks histogram/max/avg lines by position, restores byte order and issues
// addressed word writes through a 2-entry skid buffer. Malformed frames set a
// sticky error and drop input until the next end-of-frame marker.
module f15_unpack #(
  parameter int BIN_WIDTH       = 6,
  parameter int LINE_WORDS_LOG2 = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [31:0]                          i_tdata,
  input  logic                                 i_tlast,
  input  logic                                 i_teob,
  input  logic                                 i_tvalid,
  output logic                                 i_tready,
  output logic [1:0]                           wr_kind,
  output logic [BIN_WIDTH+LINE_WORDS_LOG2-1:0] wr_addr,
  output logic [31:0]                          wr_data,
  output logic                                 wr_valid,
  input  logic                                 wr_ready,
  output logic                                 frame_done,
  output logic [15:0]                          frame_cnt,
  output logic                                 err_len,
  input  logic                                 err_clear
);

  localparam int AW = BIN_WIDTH + LINE_WORDS_LOG2;

  localparam logic [1:0] S_RESYNC = 2'd0;
  localparam logic [1:0] S_HISTO  = 2'd1;
  localparam logic [1:0] S_MAX    = 2'd2;
  localparam logic [1:0] S_AVG    = 2'd3;

  logic [1:0]                 r_state;
  logic [BIN_WIDTH-1:0]       r_row;
  logic [LINE_WORDS_LOG2-1:0] r_col;
  logic                       r_tready;
  logic                       r_err;
  logic                       r_frame_done;
  logic [15:0]                r_frame_cnt;

  logic [1:0]                 r_kind  [2];
  logic [AW-1:0]              r_addr  [2];
  logic [31:0]                r_data  [2];
  logic                       r_final [2];
  logic                       r_rd;
  logic                       r_wr;
  logic [1:0]                 r_cnt;

  logic                       w_accept;
  logic                       w_line_end;
  logic                       w_eob_ok;
  logic                       w_bad;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_err;
  logic [1:0]                 w_cnt_next;
  logic [1:0]                 w_kind;
  logic [AW-1:0]              w_addr;
  logic                       w_final;
  logic [31:0]                w_data;

  // Beat classification: a beat is bad when tlast/teob disagree with position.
  always_comb begin
    w_accept   = i_tvalid & r_tready;
    w_line_end = &r_col;
    w_eob_ok   = (r_state == S_AVG) & w_line_end;
    w_bad      = (r_state != S_RESYNC) &
                 ((i_tlast != w_line_end) | (i_teob != w_eob_ok));
    w_push     = w_accept & (r_state != S_RESYNC) & ~w_bad;
    w_err      = w_accept & w_bad;
    w_pop      = (r_cnt != 2'd0) & wr_ready;
    w_cnt_next = r_cnt + 2'(w_push) - 2'(w_pop);
    w_final    = (r_state == S_AVG) & i_tlast & i_teob;
    w_data     = {i_tdata[7:0], i_tdata[15:8], i_tdata[23:16], i_tdata[31:24]};
    w_kind     = 2'd0;
    w_addr     = {r_row, r_col};
    case (r_state)
      S_MAX: begin
        w_kind = 2'd1;
        w_addr = {{BIN_WIDTH{1'b0}}, r_col};
      end
      S_AVG: begin
        w_kind = 2'd2;
        w_addr = {{BIN_WIDTH{1'b0}}, r_col};
      end
      default: ;
    endcase
  end

  // Frame position tracking; only accepted beats move the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RESYNC;
      r_row   <= '0;
      r_col   <= '0;
    end else if (w_accept) begin
      if (r_state == S_RESYNC) begin
        if (i_teob) begin
          r_state <= S_HISTO;
          r_row   <= '0;
          r_col   <= '0;
        end
      end else if (w_bad) begin
        // an offending beat carrying teob already marks a frame boundary
        r_state <= i_teob ? S_HISTO : S_RESYNC;
        r_row   <= '0;
        r_col   <= '0;
      end else if (i_tlast) begin
        r_col <= '0;
        case (r_state)
          S_HISTO: begin
            if (&r_row) begin
              r_state <= S_MAX;
              r_row   <= '0;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end
          S_MAX:   r_state <= S_AVG;
          default: begin
            r_state <= S_HISTO;
            r_row   <= '0;
          end
        endcase
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Skid buffer storage; the head entry drives the write port directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_kind[i]  <= '0;
        r_addr[i]  <= '0;
        r_data[i]  <= '0;
        r_final[i] <= 1'b0;
      end
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_cnt    <= '0;
      r_tready <= 1'b0;
    end else begin
      if (w_push) begin
        r_kind[r_wr]  <= w_kind;
        r_addr[r_wr]  <= w_addr;
        r_data[r_wr]  <= w_data;
        r_final[r_wr] <= w_final;
        r_wr          <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      r_cnt    <= w_cnt_next;
      r_tready <= (w_cnt_next != 2'd2);
    end
  end

  // Frame completion pulse and counter on the final avg write handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_frame_done <= w_pop & r_final[r_rd];
      if (w_pop & r_final[r_rd]) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Sticky framing error; a new error outranks a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_err <= 1'b0;
    else if (w_err)     r_err <= 1'b1;
    else if (err_clear) r_err <= 1'b0;
  end

  assign i_tready   = r_tready;
  assign wr_valid   = (r_cnt != 2'd0);
  assign wr_kind    = r_kind[r_rd];
  assign wr_addr    = r_addr[r_rd];
  assign wr_data    = r_data[r_rd];
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;
  assign err_len    = r_err;

endmodule

// File: tb/tb_f15_unpack.sv
// tb_f15_unpack: directed bench for f15_unpack with 4 words/line, 4 rows.
module tb_f15_unpack;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_tdata;
  logic        i_tlast, i_teob, i_tvalid, i_tready;
  logic [1:0]  wr_kind;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready, frame_done, err_len, err_clear;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr     = 0;
  int n_done   = 0;
  int acc_cnt  = 0;

  // bench reference of the framing rules
  bit m_sync = 1'b0;
  int m_line = 0;
  int m_col  = 0;
  logic [37:0] exp_q[$];

  f15_unpack #(.BIN_WIDTH(2), .LINE_WORDS_LOG2(2)) dut (
    .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .i_teob(i_teob), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .wr_kind(wr_kind), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .err_len(err_len), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [31:0] gen(input int line, input int col, input int seq);
    if (line == 2 && col == 1) return 32'h44332211;
    return {8'(seq), 8'(line), 8'(col), 8'h5A};
  endfunction

  // write monitor: handshake decided at negedge, completes at next posedge
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_done) n_done++;
      if (wr_valid && wr_ready) begin
        n_wr++;
        if (exp_q.size() == 0) check_val("unexp_write", 64'(exp_q.size()), 64'd1);
        else check_val("write", 64'({wr_kind, wr_addr, wr_data}), 64'(exp_q.pop_front()));
        if (wr_kind == 2'd0 && wr_addr == 4'h9) check_val("bswap_vec", 64'(wr_data), 64'h11223344);
      end
    end
  end

  task automatic beat(input logic [31:0] d, input logic last, input logic eob);
    bit rdy;
    bit le, we;
    if (!m_sync) begin
      if (eob) begin m_sync = 1'b1; m_line = 0; m_col = 0; end
    end else begin
      le = (m_col == 3);
      we = le && (m_line == 5);
      if (last != le || eob != we) begin
        m_sync = eob; m_line = 0; m_col = 0;
      end else begin
        exp_q.push_back({(m_line < 4) ? 2'd0 : (m_line == 4 ? 2'd1 : 2'd2),
                         (m_line < 4) ? 4'(m_line * 4 + m_col) : 4'(m_col),
                         bswap(d)});
        if (last) begin m_col = 0; m_line = (m_line == 5) ? 0 : m_line + 1; end
        else m_col++;
      end
    end
    i_tdata = d; i_tlast = last; i_teob = eob; i_tvalid = 1'b1;
    for (int t = 0; t <= 200; t++) begin
      @(negedge clk); rdy = i_tready;
      @(posedge clk); #1;
      if (rdy) break;
      if (t == 200) check_val("accept_timeout", 64'(rdy), 64'd1);
    end
    acc_cnt++;
  endtask

  // bad_type 1: early tlast, 2: extra teob, at (bad_line, bad_col)
  task automatic send_frame(input int seq, input int start_line, input int bad_type,
                            input int bad_line, input int bad_col, input bit stop);
    logic last, eob;
    for (int line = start_line; line < 6; line++) begin
      for (int col = 0; col < 4; col++) begin
        last = (col == 3);
        eob  = (line == 5 && col == 3);
        if (line == bad_line && col == bad_col) begin
          if (bad_type == 1) last = 1'b1;
          if (bad_type == 2) eob = 1'b1;
        end
        beat(gen(line, col, seq), last, eob);
        if (stop && line == bad_line && col == bad_col) begin
          i_tvalid = 1'b0; i_tlast = 1'b0; i_teob = 1'b0;
          return;
        end
      end
    end
    i_tvalid = 1'b0; i_tlast = 1'b0; i_teob = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (!wr_valid && exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check_val("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    reset = 1'b1; i_tdata = '0; i_tlast = 1'b0; i_teob = 1'b0; i_tvalid = 1'b0;
    wr_ready = 1'b1; err_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_tready", 64'(i_tready), 64'd0);
    check_val("rst_wr_valid", 64'(wr_valid), 64'd0);
    check_val("rst_wr_fields", 64'({wr_kind, wr_addr, wr_data}), 64'd0);
    check_val("rst_frame_done", 64'(frame_done), 64'd0);
    check_val("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check_val("rst_err_len", 64'(err_len), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_val("tready_after_rst", 64'(i_tready), 64'd1);

    // partial frame dropped, then one complete frame
    send_frame(1, 3, 0, -1, -1, 1'b0);
    send_frame(2, 0, 0, -1, -1, 1'b0);
    drain();
    check_val("f1_writes", 64'(n_wr), 64'd24);
    check_val("f1_frame_cnt", 64'(frame_cnt), 64'd1);
    check_val("f1_done", 64'(n_done), 64'd1);
    check_val("f1_err", 64'(err_len), 64'd0);

    // back-pressure: two accepts fill the buffer, head holds steady
    wr_ready = 1'b0;
    acc0 = acc_cnt;
    fork
      send_frame(3, 0, 0, -1, -1, 1'b0);
      begin
        repeat (8) @(posedge clk);
        #1;
        check_val("stall_accepts", 64'(acc_cnt - acc0), 64'd2);
        check_val("stall_tready", 64'(i_tready), 64'd0);
        check_val("stall_valid", 64'(wr_valid), 64'd1);
        check_val("stall_head_a", 64'({wr_kind, wr_addr, wr_data}), 64'({2'd0, 4'd0, bswap(gen(0, 0, 3))}));
        repeat (5) @(posedge clk);
        #1;
        check_val("stall_head_b", 64'({wr_kind, wr_addr, wr_data}), 64'({2'd0, 4'd0, bswap(gen(0, 0, 3))}));
        wr_ready = 1'b1;
      end
    join
    drain();
    check_val("f2_writes", 64'(n_wr), 64'd48);
    check_val("f2_frame_cnt", 64'(frame_cnt), 64'd2);

    // early tlast at row 1 col 2
    send_frame(4, 0, 1, 1, 2, 1'b0);
    drain();
    check_val("early_tlast_err", 64'(err_len), 64'd1);
    check_val("early_tlast_writes", 64'(n_wr), 64'd54);
    check_val("early_tlast_cnt", 64'(frame_cnt), 64'd2);
    send_frame(5, 0, 0, -1, -1, 1'b0);
    drain();
    check_val("f3_writes", 64'(n_wr), 64'd78);
    check_val("f3_frame_cnt", 64'(frame_cnt), 64'd3);
    check_val("f3_done", 64'(n_done), 64'd3);

    // clear alone
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    check_val("clear_alone", 64'(err_len), 64'd0);

    // teob on last word of max line: straight to histo row 0
    send_frame(6, 0, 2, 4, 3, 1'b1);
    drain();
    check_val("max_teob_err", 64'(err_len), 64'd1);
    check_val("max_teob_writes", 64'(n_wr), 64'd97);
    send_frame(7, 0, 0, -1, -1, 1'b0);
    drain();
    check_val("f4_writes", 64'(n_wr), 64'd121);
    check_val("f4_frame_cnt", 64'(frame_cnt), 64'd4);

    // clear racing a new error: error wins
    err_clear = 1'b1;
    beat(gen(0, 0, 0), 1'b1, 1'b0);
    err_clear = 1'b0;
    i_tvalid = 1'b0; i_tlast = 1'b0;
    check_val("clear_race", 64'(err_len), 64'd1);
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    check_val("clear_after_race", 64'(err_len), 64'd0);
    send_frame(8, 0, 0, -1, -1, 1'b0);
    send_frame(9, 0, 0, -1, -1, 1'b0);
    drain();
    check_val("f5_writes", 64'(n_wr), 64'd145);
    check_val("f5_frame_cnt", 64'(frame_cnt), 64'd5);

    // counter wrap
    force dut.r_frame_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.r_frame_cnt;
    @(posedge clk); #1;
    check_val("preload_cnt", 64'(frame_cnt), 64'hFFFF);
    send_frame(10, 0, 0, -1, -1, 1'b0);
    drain();
    check_val("wrap_cnt", 64'(frame_cnt), 64'h0);
    check_val("wrap_writes", 64'(n_wr), 64'd169);
    check_val("wrap_done", 64'(n_done), 64'd6);
    check_val("final_err", 64'(err_len), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
